// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier sequencer that borrows the core's shared ALU for its accumulate steps.
// Optional MULSEQ_EARLY_EXIT_EN ends the run once the remaining multiplier bits are all zero.
module alu_mul_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ALU_CONTROL_BITS = 3,
    parameter logic [ALU_CONTROL_BITS-1:0] ADD_SUB_OP = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       core_a,
    input  logic [DATA_WIDTH-1:0]       core_b,
    input  logic [ALU_CONTROL_BITS-1:0] core_alu_control,
    input  logic                        core_signed_flag,
    output logic [DATA_WIDTH-1:0]       core_q,
    output logic                        core_less,
    output logic                        core_equal,
    output logic                        busy,
    input  logic                        mul_valid,
    output logic                        mul_ready,
    input  logic [DATA_WIDTH-1:0]       mul_a,
    input  logic [DATA_WIDTH-1:0]       mul_b,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [DATA_WIDTH-1:0]       res_q,
    output logic [DATA_WIDTH-1:0]       alu_a,
    output logic [DATA_WIDTH-1:0]       alu_b,
    output logic [ALU_CONTROL_BITS-1:0] alu_control,
    output logic                        alu_signed_flag,
    input  logic [DATA_WIDTH-1:0]       alu_q,
    input  logic                        alu_less,
    input  logic                        alu_equal
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign res_q = acc_q;

    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        mcand_d         = mcand_q;
        mplier_d        = mplier_q;
        cnt_d           = cnt_q;
        alu_a           = core_a;
        alu_b           = core_b;
        alu_control     = core_alu_control;
        alu_signed_flag = core_signed_flag;
        core_q          = alu_q;
        core_less       = alu_less;
        core_equal      = alu_equal;
        busy            = 1'b0;
        mul_ready       = 1'b0;
        res_valid       = 1'b0;

        unique case (state_q)
            StIdle: begin
                mul_ready = 1'b1;
                if (mul_valid) begin
                    acc_d    = '0;
                    mcand_d  = mul_a;
                    mplier_d = mul_b;
                    cnt_d    = '0;
                    state_d  = StRun;
`ifdef MULSEQ_EARLY_EXIT_EN
                    if (mul_b == '0) state_d = StDone;
`endif
                end
            end
            StRun: begin
                busy            = 1'b1;
                alu_a           = acc_q;
                alu_b           = mcand_q;
                alu_control     = ADD_SUB_OP;
                alu_signed_flag = 1'b0;
                core_q          = '0;
                core_less       = 1'b0;
                core_equal      = 1'b0;
                if (mplier_q[0]) acc_d = alu_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntLast) state_d = StDone;
`ifdef MULSEQ_EARLY_EXIT_EN
                if (mplier_d == '0) state_d = StDone;
`endif
            end
            StDone: begin
                res_valid = 1'b1;
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed plus random bench for alu_mul_sequencer with a behavioural ALU and product/latency model.
module tb_alu_mul_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned CB = 3;
    localparam logic [CB-1:0] ADD_OP = 3'd0;
    localparam logic [CB-1:0] XOR_OP = 3'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] core_a = '0, core_b = '0;
    logic [CB-1:0] core_alu_control = '0;
    logic          core_signed_flag = 1'b0;
    logic [DW-1:0] core_q;
    logic          core_less, core_equal, busy;
    logic          mul_valid = 1'b0;
    logic          mul_ready;
    logic [DW-1:0] mul_a = '0, mul_b = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_q;
    logic [DW-1:0] alu_a, alu_b, alu_q;
    logic [CB-1:0] alu_control;
    logic          alu_signed_flag, alu_less, alu_equal;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_mul_sequencer #(.DATA_WIDTH(DW), .ALU_CONTROL_BITS(CB), .ADD_SUB_OP(ADD_OP)) dut (
        .clk(clk), .rst(rst),
        .core_a(core_a), .core_b(core_b), .core_alu_control(core_alu_control),
        .core_signed_flag(core_signed_flag), .core_q(core_q), .core_less(core_less),
        .core_equal(core_equal), .busy(busy),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_a(mul_a), .mul_b(mul_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_signed_flag(alu_signed_flag), .alu_q(alu_q), .alu_less(alu_less),
        .alu_equal(alu_equal)
    );

    // Stand-in for the shared ALU.
    always_comb begin
        alu_q = alu_a & alu_b;
        if (alu_control == ADD_OP) alu_q = alu_a + alu_b;
        else if (alu_control == XOR_OP) alu_q = alu_a ^ alu_b;
        alu_less  = alu_a < alu_b;
        alu_equal = alu_a == alu_b;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Cycles from the accepting edge (counted as 1) until res_valid is visible.
    function automatic int exp_latency(input logic [DW-1:0] b);
`ifdef MULSEQ_EARLY_EXIT_EN
        int h;
        if (b == '0) return 1;
        h = 0;
        for (int i = 0; i < int'(DW); i++) if (b[i]) h = i;
        return h + 2;
`else
        return int'(DW) + 1;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        check("ready_before_req", {63'd0, mul_ready}, 64'd1);
        mul_a = a;
        mul_b = b;
        mul_valid = 1'b1;
        step();
        mul_valid = 1'b0;
        mul_a = $urandom;
        mul_b = $urandom;
    endtask

    task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
        logic [DW-1:0] exp_p;
        int lat;
        int busy_cnt;
        int run_bad;
        exp_p = DW'(64'(a) * 64'(b));
        start_mul(a, b);
        lat = 1;
        busy_cnt = 0;
        run_bad = 0;
        while (!res_valid && lat < 200) begin
            if (busy) begin
                busy_cnt++;
                if (core_q !== '0 || alu_control !== ADD_OP || mul_ready !== 1'b0) run_bad++;
            end
            step();
            lat++;
        end
        check("res_valid_seen", {63'd0, res_valid}, 64'd1);
        check("latency", 64'(lat), 64'(exp_latency(b)));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_latency(b) - 1));
        check("run_outputs", 64'(run_bad), 64'd0);
        check("product", 64'(res_q), 64'(exp_p));
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", {61'd0, res_valid, mul_ready, busy}, 64'b100);
            check("hold_q", 64'(res_q), 64'(exp_p));
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("back_idle", {62'd0, mul_ready, res_valid}, 64'b10);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, mul_ready}, 64'd1);
        check("rst_valid", {63'd0, res_valid}, 64'd0);
        check("rst_res_q", 64'(res_q), 64'd0);

        core_a = 32'h0F0F;
        core_b = 32'h00FF;
        core_alu_control = XOR_OP;
        #1;
        check("pass_xor", 64'(core_q), 64'h0FF0);
        check("pass_busy", {63'd0, busy}, 64'd0);

        run_mul(32'd7, 32'd6, 5);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_mul(32'h8000_0000, 32'd2, 0);
        run_mul(32'd5, 32'd3, 0);
        run_mul(32'd9, 32'd0, 1);

        // Abort mid-run; the passthrough must be live right after reset.
        start_mul(32'd11, 32'hFFFF_0000);
        for (int i = 0; i < 10; i++) step();
        check("abort_busy_pre", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("abort_state", {61'd0, busy, res_valid, mul_ready}, 64'b001);
        check("abort_pass", 64'(core_q), 64'(core_a ^ core_b));
        run_mul(32'd3, 32'd5, 0);

        for (int n = 0; n < 8; n++) begin
            logic [DW-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom >> $urandom_range(31, 0);
            core_a = $urandom;
            core_b = $urandom;
            run_mul(ra, rb, $urandom_range(2, 0));
            #1;
            check("rand_pass", 64'(core_q), 64'(core_a ^ core_b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
